// File: rtl/rgmii_rx_decoder.sv
// RGMII receive front end: DDR nibble/control capture, frame qualification and
// byte assembly with one-byte look-ahead so the final byte of a frame carries last.
module rgmii_rx_decoder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       rxClk,
    input  logic       rstLcl,
    input  logic [3:0] rxDataIn,
    input  logic       rxCtrlIn,
    input  logic       intBIn,
    input  logic       mmcmLockedIn,
    output logic [7:0] rxDataOut,
    output logic       rxDataValidOut,
    output logic       rxDataLastOut
);
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    logic [NIB_W-1:0]       rise_nib;
    logic [NIB_W-1:0]       fall_nib;
    logic                   dv;
    logic                   ctl2;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] int_b_sync;
    logic                   int_b_unused;
    logic                   locked;
    logic                   er;
    logic                   good;
    state_t                 state;
    logic [BYTE_W-1:0]      asm_byte;
    logic                   asm_valid;
    logic [BYTE_W-1:0]      hold_byte;
    logic                   hold_valid;

    // Rising edge carries the low nibble and RX_DV.
    always_ff @(posedge rxClk or negedge rstLcl) begin
        if (!rstLcl) begin
            rise_nib <= '0;
            dv       <= 1'b0;
        end else begin
            rise_nib <= rxDataIn;
            dv       <= rxCtrlIn;
        end
    end

    // Falling edge carries the high nibble and RX_DV XOR RX_ER.
    always_ff @(negedge rxClk or negedge rstLcl) begin
        if (!rstLcl) begin
            fall_nib <= '0;
            ctl2     <= 1'b0;
        end else begin
            fall_nib <= rxDataIn;
            ctl2     <= rxCtrlIn;
        end
    end

    always_ff @(posedge rxClk or negedge rstLcl) begin
        if (!rstLcl) begin
            lock_sync  <= '0;
            int_b_sync <= '0;
        end else begin
            lock_sync  <= {lock_sync[SYNC_STAGES-2:0], mmcmLockedIn};
            int_b_sync <= {int_b_sync[SYNC_STAGES-2:0], intBIn};
        end
    end

    // The interrupt is only brought into the clock domain; nothing consumes it yet.
    assign int_b_unused = int_b_sync[SYNC_STAGES-1];
    assign locked       = lock_sync[SYNC_STAGES-1];
    assign er           = dv ^ ctl2;
    assign good         = dv & locked & ~er;

    // Frame qualification: a frame is accepted only if it starts clean and locked.
    always_ff @(posedge rxClk or negedge rstLcl) begin
        if (!rstLcl) begin
            state     <= IDLE;
            asm_byte  <= '0;
            asm_valid <= 1'b0;
        end else begin
            asm_byte  <= {fall_nib, rise_nib};
            asm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (good) begin
                        state     <= RECV;
                        asm_valid <= 1'b1;
                    end else if (dv) begin
                        state <= DROP;
                    end
                end
                RECV: begin
                    if (good) begin
                        asm_valid <= 1'b1;
                    end else if (!dv) begin
                        state <= IDLE;
                    end else begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (!dv) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Look-ahead: a held byte is last when no accepted byte follows it.
    always_ff @(posedge rxClk or negedge rstLcl) begin
        if (!rstLcl) begin
            hold_byte      <= '0;
            hold_valid     <= 1'b0;
            rxDataOut      <= '0;
            rxDataValidOut <= 1'b0;
            rxDataLastOut  <= 1'b0;
        end else begin
            rxDataValidOut <= 1'b0;
            rxDataLastOut  <= 1'b0;
            if (hold_valid) begin
                rxDataOut      <= hold_byte;
                rxDataValidOut <= 1'b1;
                rxDataLastOut  <= ~asm_valid;
            end
            if (asm_valid) begin
                hold_byte <= asm_byte;
            end
            hold_valid <= asm_valid;
        end
    end

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed bench for rgmii_rx_decoder: drives DDR bytes, collects the output
// stream and compares it with hand-derived expected frames.
module tb_rgmii_rx_decoder;
    logic       rxClk = 1'b0;
    logic       rstLcl;
    logic [3:0] rxDataIn;
    logic       rxCtrlIn;
    logic       intBIn;
    logic       mmcmLockedIn;
    logic [7:0] rxDataOut;
    logic       rxDataValidOut;
    logic       rxDataLastOut;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_wo_valid = 0;

    logic [7:0] got_data[$];
    logic       got_last[$];
    int         got_cyc[$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];

    rgmii_rx_decoder #(.SYNC_STAGES(2)) dut (
        .rxClk          (rxClk),
        .rstLcl         (rstLcl),
        .rxDataIn       (rxDataIn),
        .rxCtrlIn       (rxCtrlIn),
        .intBIn         (intBIn),
        .mmcmLockedIn   (mmcmLockedIn),
        .rxDataOut      (rxDataOut),
        .rxDataValidOut (rxDataValidOut),
        .rxDataLastOut  (rxDataLastOut)
    );

    always #4 rxClk = ~rxClk;

    always @(posedge rxClk) cyc <= cyc + 1;

    always @(negedge rxClk) begin
        if (rxDataValidOut === 1'b1) begin
            got_data.push_back(rxDataOut);
            got_last.push_back(rxDataLastOut);
            got_cyc.push_back(cyc);
        end else if (rxDataLastOut !== 1'b0) begin
            last_wo_valid++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One byte: low nibble/cr around the rising edge, high nibble/cf around the falling edge.
    task automatic drive_byte(input logic [7:0] b, input logic cr, input logic cf);
        @(negedge rxClk);
        #2;
        rxDataIn = b[3:0];
        rxCtrlIn = cr;
        @(posedge rxClk);
        #2;
        rxDataIn = b[7:4];
        rxCtrlIn = cf;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input logic [7:0] base, input int er_idx,
                              input int lock_idx, input logic lock_val, output int first_cyc);
        first_cyc = 0;
        for (int i = 0; i < n; i++) begin
            drive_byte(8'(base + i), 1'b1, (i == er_idx) ? 1'b0 : 1'b1);
            if (i == 0) first_cyc = cyc;
            if (i == lock_idx) mmcmLockedIn = lock_val;
        end
    endtask

    task automatic exp_frame(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            exp_data.push_back(8'(base + i));
            exp_last.push_back(i == n - 1);
        end
    endtask

    task automatic clear_queues();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_count"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s_last%0d", tag, i), got_last[i], exp_last[i]);
        end
        clear_queues();
    endtask

    initial begin
        int fc;
        rstLcl       = 1'b0;
        rxDataIn     = 4'h0;
        rxCtrlIn     = 1'b1;
        intBIn       = 1'bx;
        mmcmLockedIn = 1'b1;

        // Reset held with RX_CTL high and data toggling
        for (int i = 0; i < 6; i++) begin
            drive_byte(8'(i * 37 + 5), 1'b1, 1'b1);
            #1;
            check("rst_valid", rxDataValidOut, 1'b0);
            check("rst_last", rxDataLastOut, 1'b0);
            check("rst_data", rxDataOut, 8'h00);
        end
        rxCtrlIn = 1'b0;
        @(negedge rxClk);
        #2;
        rstLcl = 1'b1;
        idle(5);
        clear_queues();

        // Long frame: 1440 incrementing bytes
        send_frame(1440, 8'h00, -1, -1, 1'b1, fc);
        idle(6);
        exp_frame(1440, 8'h00);
        if (got_cyc.size() > 0)
            check("long_gapless", got_cyc[got_cyc.size() - 1] - got_cyc[0], 32'd1439);
        compare_frames("long");

        // Single byte frame with latency measurement
        intBIn = 1'b1;
        send_frame(1, 8'hA5, -1, -1, 1'b1, fc);
        idle(6);
        if (got_cyc.size() > 0)
            check("single_latency", got_cyc[0] - fc, 32'd3);
        exp_frame(1, 8'hA5);
        compare_frames("single");

        // Two 4-byte frames separated by one idle cycle
        send_frame(4, 8'h10, -1, -1, 1'b1, fc);
        idle(1);
        send_frame(4, 8'h20, -1, -1, 1'b1, fc);
        idle(6);
        exp_frame(4, 8'h10);
        exp_frame(4, 8'h20);
        compare_frames("b2b");

        // Frame begins unlocked, lock rises mid-frame: whole frame discarded
        mmcmLockedIn = 1'b0;
        idle(4);
        send_frame(10, 8'h50, -1, 3, 1'b1, fc);
        idle(5);
        send_frame(5, 8'h60, -1, -1, 1'b1, fc);
        idle(6);
        exp_frame(5, 8'h60);
        compare_frames("lockrise");

        // RX_ER on the third byte of six
        send_frame(6, 8'h31, 2, -1, 1'b1, fc);
        idle(3);
        send_frame(3, 8'h70, -1, -1, 1'b1, fc);
        idle(6);
        exp_frame(2, 8'h31);
        exp_frame(3, 8'h70);
        compare_frames("rxer");

        // Lock lost mid-frame: bytes in flight before the sync delay complete, then last
        send_frame(6, 8'h40, -1, 1, 1'b0, fc);
        idle(3);
        mmcmLockedIn = 1'b1;
        idle(4);
        send_frame(2, 8'h80, -1, -1, 1'b1, fc);
        idle(6);
        exp_frame(3, 8'h40);
        exp_frame(2, 8'h80);
        compare_frames("lockloss");

        // Reset mid-frame: outputs clear at once, no trailing last
        send_frame(4, 8'h90, -1, -1, 1'b1, fc);
        #1;
        rstLcl = 1'b0;
        #1;
        check("midrst_valid", rxDataValidOut, 1'b0);
        check("midrst_last", rxDataLastOut, 1'b0);
        check("midrst_data", rxDataOut, 8'h00);
        clear_queues();
        idle(3);
        rstLcl = 1'b1;
        idle(6);
        compare_frames("midrst_quiet");
        send_frame(2, 8'hC0, -1, -1, 1'b1, fc);
        idle(6);
        exp_frame(2, 8'hC0);
        compare_frames("post_rst");

        check("last_without_valid", last_wo_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
